// File: rtl/bsg_contract_bitmask_serial_if.sv
// Handshake bundle for bsg_contract_bitmask_serial.
// Signal names are taken from the block's point of view: _i is driven into the block, _o out of it.
interface bsg_contract_bitmask_serial_if #(
  parameter int unsigned out_width_p  = 16,
  parameter int unsigned beat_width_p = 64
) ();
  logic                    v_i;
  logic [beat_width_p-1:0] data_i;
  logic                    ready_o;
  logic                    v_o;
  logic [out_width_p-1:0]  data_o;
  logic                    err_o;
  logic                    ready_i;

  // The contraction block itself
  modport slave (
    input  v_i, data_i, ready_i,
    output ready_o, v_o, data_o, err_o
  );

  // Producer/consumer environment around the block
  modport master (
    output v_i, data_i, ready_i,
    input  ready_o, v_o, data_o, err_o
  );
endinterface

// File: rtl/bsg_contract_bitmask_serial.sv
// Serial bitmask contractor: gathers an expanded mask over N beats and collapses each
// expand_p-bit group to one bit (OR-reduction), presenting one contracted mask per N beats.
// Optional macro BSG_CONTRACT_BITMASK_CHECK_EN adds a sticky per-mask flag on err_o for any
// group that is neither all-zero nor all-one; without it err_o is tied low.
module bsg_contract_bitmask_serial #(
  parameter int unsigned out_width_p  = 16,
  parameter int unsigned expand_p     = 32,
  parameter int unsigned beat_width_p = 64
) (
  input logic                           clk_i,
  input logic                           reset_n_i,
  bsg_contract_bitmask_serial_if.slave  bus_io
);

  localparam int unsigned G    = beat_width_p / expand_p;
  localparam int unsigned N    = (out_width_p * expand_p) / beat_width_p;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(N - 1);

  if ((beat_width_p % expand_p) != 0 || ((out_width_p * expand_p) % beat_width_p) != 0) begin : g_bad_cfg
    $error("bsg_contract_bitmask_serial: inconsistent width parameters");
  end

  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [out_width_p-1:0] acc_q, acc_d;
  logic [out_width_p-1:0] mask_next;
  logic                   v_q, v_d;
  logic [out_width_p-1:0] data_q, data_d;
  logic [G-1:0]           grp_or;
  logic                   ready;
  logic                   accept;
  logic                   last;

  // Only stall when the final beat would have nowhere to go.
  assign ready  = !((cnt_q == LastBeat) && v_q && !bus_io.ready_i);
  assign accept = bus_io.v_i && ready;
  assign last   = accept && (cnt_q == LastBeat);

  assign bus_io.ready_o = ready;
  assign bus_io.v_o     = v_q;
  assign bus_io.data_o  = data_q;

  // Per-group OR of the current beat.
  always_comb begin
    grp_or = '0;
    for (int unsigned g = 0; g < G; g++) begin
      grp_or[g] = |bus_io.data_i[g*expand_p +: expand_p];
    end
  end

  // Merge the current beat into the accumulator; beat 0 starts from a clean mask.
  always_comb begin
    mask_next = (cnt_q == '0) ? '0 : acc_q;
    for (int unsigned g = 0; g < out_width_p; g++) begin
      if (CntW'(g / G) == cnt_q) begin
        mask_next[g] = grp_or[g % G];
      end
    end
  end

  // Next-state for beat counter, accumulator and output register.
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    v_d    = v_q;
    data_d = data_q;
    if (accept) begin
      acc_d = mask_next;
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
    if (last) begin
      v_d    = 1'b1;
      data_d = mask_next;
    end else if (v_q && bus_io.ready_i) begin
      v_d = 1'b0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      v_q    <= v_d;
      data_q <= data_d;
    end
  end

`ifdef BSG_CONTRACT_BITMASK_CHECK_EN
  logic err_acc_q, err_acc_d;
  logic err_q, err_d;
  logic err_next;

  // A group is non-uniform when it has some ones but is not all ones.
  always_comb begin
    logic beat_err;
    beat_err = 1'b0;
    for (int unsigned g = 0; g < G; g++) begin
      beat_err = beat_err | (grp_or[g] & ~(&bus_io.data_i[g*expand_p +: expand_p]));
    end
    err_next  = ((cnt_q == '0) ? 1'b0 : err_acc_q) | beat_err;
    err_acc_d = accept ? err_next : err_acc_q;
    err_d     = last ? err_next : err_q;
  end

  // Error accumulator and error flag travelling with the output mask.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      err_acc_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_acc_q <= err_acc_d;
      err_q     <= err_d;
    end
  end

  assign bus_io.err_o = err_q;
`else
  assign bus_io.err_o = 1'b0;
`endif

endmodule
